// File: rtl/fetch_exec_sequencer.sv
// Multicycle fetch/execute sequencer for the 16-bit core.
// Holds PC, the instruction register, A, D and the latched M operand. It
// sequences FETCH -> [MREAD] -> EXEC -> [WRITE] over one shared memory port
// that uses a level req / one-cycle ack handshake.
module fetch_exec_sequencer #(
    parameter int               WIDTH    = 16,
    parameter logic [WIDTH-1:0] RESET_PC = 16'h0000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    // memory port
    output logic [WIDTH-1:0] mem_addr,
    output logic             mem_rd_req,
    output logic             mem_wr_req,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ack,
    // architectural state, fed to the control unit
    output logic [WIDTH-1:0] instr,
    output logic [WIDTH-1:0] reg_a,
    output logic [WIDTH-1:0] reg_d,
    output logic [WIDTH-1:0] reg_m,
    // decode results from the control unit
    input  logic [WIDTH-1:0] addr_out,
    input  logic             instr_type,
    input  logic             reg_a_en,
    input  logic             reg_d_en,
    input  logic             reg_m_en,
    input  logic             set_pc,
    input  logic [WIDTH-1:0] alu_result,
    // status
    output logic [WIDTH-1:0] pc,
    output logic             retire,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_MREAD = 2'd1,
        S_EXEC  = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_instr;
    logic [WIDTH-1:0] r_reg_a;
    logic [WIDTH-1:0] r_reg_d;
    logic [WIDTH-1:0] r_reg_m;
    logic [WIDTH-1:0] r_wdata;
    logic [WIDTH-1:0] r_waddr;
    logic             r_fetch_pend;

    logic             w_fetch_req;
    logic             w_rd_req;
    logic             w_wr_req;
    logic [WIDTH-1:0] w_addr;
    logic             w_retire;
    logic             w_mwrite;

    // A fetch request, once raised, stays up until acked even if run drops.
    assign w_fetch_req = run | r_fetch_pend;

    // Next-state and request decode for the sequencer FSM.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case statement can leave a signal unassigned (latch).
        w_next   = r_state;
        w_rd_req = 1'b0;
        w_wr_req = 1'b0;
        w_addr   = r_pc;
        w_retire = 1'b0;
        w_mwrite = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_rd_req = w_fetch_req;
                if (w_fetch_req && mem_ack) begin
                    w_next = mem_rdata[WIDTH-1] ? S_EXEC : S_MREAD;
                end
            end
            S_MREAD: begin
                w_rd_req = 1'b1;
                w_addr   = r_reg_a;
                if (mem_ack) begin
                    w_next = S_EXEC;
                end
            end
            S_EXEC: begin
                w_retire = 1'b1;
                w_mwrite = reg_m_en & ~instr_type;
                w_next   = w_mwrite ? S_WRITE : S_FETCH;
            end
            S_WRITE: begin
                w_wr_req = 1'b1;
                w_addr   = r_waddr;
                if (mem_ack) begin
                    w_next = S_FETCH;
                end
            end
            default: w_next = S_FETCH;
        endcase
    end

    // State register plus the held-fetch flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_FETCH;
            r_fetch_pend <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_fetch_pend <= (r_state == S_FETCH) && w_fetch_req && !mem_ack;
        end
    end

    // Architectural state: instruction/operand capture and EXEC commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc    <= RESET_PC;
            r_instr <= '0;
            r_reg_a <= '0;
            r_reg_d <= '0;
            r_reg_m <= '0;
            r_wdata <= '0;
            r_waddr <= '0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (w_fetch_req && mem_ack) begin
                        r_instr <= mem_rdata;
                    end
                end
                S_MREAD: begin
                    if (mem_ack) begin
                        r_reg_m <= mem_rdata;
                    end
                end
                S_EXEC: begin
                    // NOTE: non-blocking updates mean every right-hand r_reg_a
                    // below reads the pre-commit A, which is exactly what the
                    // jump target and the M write address must use.
                    if (reg_a_en) begin
                        r_reg_a <= instr_type ? addr_out : alu_result;
                    end
                    if (reg_d_en) begin
                        r_reg_d <= alu_result;
                    end
                    r_pc <= set_pc ? r_reg_a : r_pc + ONE;
                    if (w_mwrite) begin
                        r_wdata <= alu_result;
                        r_waddr <= r_reg_a;
                    end
                end
                default: ;
            endcase
        end
    end

    // Requests and retire are gated by rst_n so they fall the instant reset
    // is asserted rather than at the next clock edge.
    assign mem_rd_req = rst_n & w_rd_req;
    assign mem_wr_req = rst_n & w_wr_req;
    assign retire     = rst_n & w_retire;
    assign busy       = rst_n & ((r_state != S_FETCH) | w_fetch_req);
    assign mem_addr   = w_addr;
    assign mem_wdata  = r_wdata;
    assign instr      = r_instr;
    assign reg_a      = r_reg_a;
    assign reg_d      = r_reg_d;
    assign reg_m      = r_reg_m;
    assign pc         = r_pc;

endmodule

// File: doc/fetch_exec_sequencer.md
Name: fetch_exec_sequencer

Overview:
- Multicycle fetch/execute sequencer and architectural state holder for the 16-bit core.
- Owns PC, instruction register, A, D and the latched M operand. Feeds the control unit's instr, reg_a_in, reg_d_in and reg_m_in inputs.
- Consumes the control unit's decode outputs plus the ALU result to commit writes and update PC.
- Talks to a single shared instruction/data memory over a level req/ack handshake.

Parameters:
- WIDTH, 16, datapath/address width; only 16 is supported.
- RESET_PC, 16'h0000, PC value after reset.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- run  in  1  permits a new fetch to start
- mem_addr  out  16  memory address
- mem_rd_req  out  1  read request, held until ack
- mem_wr_req  out  1  write request, held until ack
- mem_wdata  out  16  write data
- mem_rdata  in  16  read data, valid with mem_ack
- mem_ack  in  1  one-cycle completion strobe
- instr  out  16  instruction register, to control unit
- reg_a  out  16  A register
- reg_d  out  16  D register
- reg_m  out  16  latched M = mem[A]
- addr_out  in  16  A-type immediate from control unit
- instr_type  in  1  1 = A-type instruction
- reg_a_en  in  1  write A
- reg_d_en  in  1  write D
- reg_m_en  in  1  write mem[A]
- set_pc  in  1  take jump
- alu_result  in  16  ALU output
- pc  out  16  program counter
- retire  out  1  one-cycle pulse per completed EXEC
- busy  out  1  high in any state except idle FETCH

Behaviour:
- Reset (async, rst_n low):
  - state=FETCH; pc=RESET_PC; instr, reg_a, reg_d, reg_m, mem_wdata = 0.
  - All req outputs and retire drop to 0 immediately, without waiting for a clock edge.
  - A reset mid-transaction abandons that transaction. An ack arriving after reset is ignored.
- FETCH:
  - With run=1: mem_rd_req=1, mem_addr=pc. With run=0: no request, busy=0.
  - On mem_ack: instr<=mem_rdata.
  - Next state: EXEC if mem_rdata[15]=1, otherwise MREAD.
- MREAD: mem_rd_req=1, mem_addr=reg_a. On mem_ack: reg_m<=mem_rdata, go to EXEC.
- EXEC (exactly 1 cycle; control unit outputs are combinational from instr/regs):
  - A write: reg_a<= instr_type ? addr_out : alu_result when reg_a_en.
  - D write: reg_d<=alu_result when reg_d_en.
  - PC: pc<= set_pc ? reg_a(pre-commit value) : pc+1, with 16'hFFFF+1 wrapping to 16'h0000.
  - M write: if reg_m_en & ~instr_type, mem_wdata<=alu_result, capture waddr<=reg_a (pre-commit), go to WRITE. Otherwise go to FETCH.
  - retire=1 for this cycle.
- WRITE: mem_wr_req=1, mem_addr=waddr, mem_wdata held. On mem_ack go to FETCH.
- Simultaneous A and M writes: M goes to the old A address and A takes the new value.
- Jump: the target is the old A, even when the same instruction writes A.
- run is sampled only in FETCH. Deasserting it mid-instruction completes that instruction, then idles.
- mem_ack while no request is asserted: ignored.
- mem_rd_req and mem_wr_req are never high together.
- All requests are held stable until acked; there is no timeout.
- Latency:
  - A-type: fetch_latency + 1.
  - C-type without M write: 2 memory transactions + 1.
  - C-type with M write: 3 memory transactions + 1.

Test Plan:
- Reset, run=1, memory returns 16'h8005 at addr 0 with 1-cycle ack → reg_a=16'h0005, pc=1, retire pulses once, no MREAD issued.
- After reg_a=5, fetch 16'h2000 (D dest); bench ALU drives 16'h1234; mem[5]=16'hBEEF → MREAD at addr 5, reg_m=BEEF, reg_d=1234, pc=2, no write request.
- reg_a=16'h0040, instr 16'h5000 (A+M dest), alu_result=16'h0077 → reg_a=0077; write request to addr 0040 with data 0077; pc+1.
- reg_a=16'h0030, instr 16'h4007 (A dest, unconditional jump), alu_result=16'h0099 → pc=0030 (old A), reg_a=0099.
- pc=16'hFFFF, A-type fetched, no jump → pc wraps to 16'h0000.
- Assert rst_n=0 while mem_wr_req=1 and ack pending → wr_req drops asynchronously; after release the first request is a fetch at RESET_PC. Also run=0 at FETCH → no request, busy=0.
